// File: rtl/rdcla_issue_ctrl.sv
`default_nettype none
// ============================================================================
// rdcla_issue_ctrl
//   Issue/collect wrapper around a free-running pipelined CLA adder: operand
//   handshake in, credit-protected result FIFO out.
//   Revision: 1.0
// ============================================================================
module rdcla_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic [WIDTH-1:0] add_in1,
  output logic [WIDTH-1:0] add_in2,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]  credits;
  logic [CW-1:0]  count;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LAT:0]   vsr;
  logic [WIDTH:0] mem [DEPTH];
  logic           accept;
  logic           pop;
  logic           wr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on registered credits, so it never waits on req_valid.
  assign req_ready = (credits != '0) && !rst;
  assign accept    = req_valid && req_ready;
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign wr        = vsr[LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_in1 <= '0;
      add_in2 <= '0;
      add_cin <= 1'b0;
    end else if (accept) begin
      add_in1 <= req_a;
      add_in2 <= req_b;
      add_cin <= req_cin;
    end
  end

  generate
    if (LAT == 0) begin : g_vsr_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vsr <= '0;
        else     vsr <= accept;
      end
    end else begin : g_vsr_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vsr <= '0;
        else     vsr <= {vsr[LAT-1:0], accept};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CW'(DEPTH);
    end else if (accept && !pop) begin
      credits <= credits - CW'(1);
    end else if (pop && !accept) begin
      credits <= credits + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr)  wr_ptr <= ptr_next(wr_ptr);
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (wr && !pop)      count <= count + CW'(1);
      else if (pop && !wr) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {add_cout, add_sum};
  end

  assign {res_cout, res_sum} = res_valid ? mem[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_rdcla_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rdcla_issue_ctrl
//   Scoreboard bench: three wrappers (LAT 2, 0, 5) around behavioural adders.
//   Revision: 1.0
// ============================================================================
module tb_rdcla_issue_ctrl;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_cin;
  logic        res_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;

  int checks = 0;
  int errors = 0;
  int acc0   = 0;
  int cyc    = 0;
  int t_acc  = -1;
  int t_val  = -1;
  logic arm  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar i = 0; i < N; i++) begin : g_inst
    localparam int L = (i == 0) ? 2 : ((i == 1) ? 0 : 5);
    logic        req_ready, add_cin, add_cout, res_valid, res_cout;
    logic [31:0] add_in1, add_in2, add_sum, res_sum;
    logic [32:0] q [$];
    logic [32:0] e;

    rdcla_issue_ctrl #(.WIDTH(32), .LAT(L), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_cout(res_cout)
    );

    if (L == 0) begin : g_add
      assign {add_cout, add_sum} = {1'b0, add_in1} + {1'b0, add_in2} + 33'(add_cin);
    end else begin : g_add
      logic [32:0] stg [L];
      always_ff @(posedge clk) begin
        stg[0] <= {1'b0, add_in1} + {1'b0, add_in2} + 33'(add_cin);
        for (int k = 1; k < L; k++) stg[k] <= stg[k-1];
      end
      assign {add_cout, add_sum} = stg[L-1];
    end

    // Handshakes are evaluated at the falling edge, i.e. what the next rising edge will see.
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        if (req_valid && req_ready) begin
          q.push_back({1'b0, req_a} + {1'b0, req_b} + 33'(req_cin));
          if (i == 0) acc0++;
        end
        if (res_valid && res_ready) begin
          if (q.size() == 0) begin
            check_eq($sformatf("spurious%0d", i), 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check_eq($sformatf("res%0d", i), {31'd0, res_cout, res_sum}, {31'd0, e});
          end
        end
        if (!res_valid) check_eq($sformatf("empty_out%0d", i), {31'd0, res_cout, res_sum}, 64'd0);
        check_eq($sformatf("full_wr%0d", i), 64'((int'(u_dut.count) == DEPTH) && u_dut.vsr[L]), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (arm && t_acc < 0 && req_valid && g_inst[0].req_ready) t_acc = cyc;
    if (arm && t_val < 0 && g_inst[0].res_valid) t_val = cyc;
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c);
    int n = 0;
    req_valid = 1'b1; req_a = a; req_b = b; req_cin = c;
    forever begin
      @(negedge clk);
      if (g_inst[0].req_ready) break;
      n++;
      if (n > 200) begin
        check_eq("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic hold_cycles(input int n);
    logic acc;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      acc = req_valid && g_inst[0].req_ready;
      @(posedge clk); #1;
      if (acc) begin
        req_a = $urandom; req_b = $urandom; req_cin = 1'($urandom);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0; res_ready = 1'b1;
    while ((g_inst[0].q.size() + g_inst[1].q.size() + g_inst[2].q.size()) != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_timeout", 64'(n >= 500), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int a0;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset with three operations in flight
    send(32'd1, 32'd2, 1'b0);
    send(32'd3, 32'd4, 1'b0);
    send(32'd5, 32'd6, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_res_valid", 64'(g_inst[0].res_valid), 64'd0);
    check_eq("rst_add_in1", 64'(g_inst[0].add_in1), 64'd0);
    check_eq("rst_add_in2", 64'(g_inst[0].add_in2), 64'd0);
    check_eq("rst_add_cin", 64'(g_inst[0].add_cin), 64'd0);
    check_eq("rst_req_ready", 64'(g_inst[0].req_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    check_eq("rst_credits", 64'(g_inst[0].u_dut.credits), 64'(DEPTH));
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("stale", 64'(g_inst[0].res_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Back-to-back basic sequence and first-result latency
    arm = 1'b1;
    send(32'd33, 32'd12, 1'b0);
    send(32'd3, 32'd12, 1'b0);
    send(32'd13, 32'd12, 1'b0);
    send(32'd113, 32'd121, 1'b0);
    drain();
    arm = 1'b0;
    check_eq("latency", 64'(t_val - t_acc - 1), 64'd3);

    // Carry boundaries
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1);
    drain();

    // Backpressure: credits cap outstanding work at DEPTH
    res_ready = 1'b0; req_valid = 1'b1;
    req_a = $urandom; req_b = $urandom; req_cin = 1'b0;
    a0 = acc0;
    hold_cycles(10);
    check_eq("bp_accepts", 64'(acc0 - a0), 64'(DEPTH));
    check_eq("bp_ready_low", 64'(g_inst[0].req_ready), 64'd0);
    res_ready = 1'b1;
    hold_cycles(1);
    res_ready = 1'b0;
    a0 = acc0;
    hold_cycles(6);
    check_eq("bp_one_more", 64'(acc0 - a0), 64'd1);

    // Pop at zero credits frees a slot that the very next edge uses
    res_ready = 1'b1;
    a0 = acc0;
    hold_cycles(1);
    check_eq("sim_no_accept", 64'(acc0 - a0), 64'd0);
    hold_cycles(1);
    check_eq("sim_accept", 64'(acc0 - a0), 64'd1);
    hold_cycles(16);
    drain();
    check_eq("wrap_credits", 64'(g_inst[0].u_dut.credits), 64'(DEPTH));
    check_eq("wrap_count", 64'(g_inst[0].u_dut.count), 64'd0);

    // Randomized traffic
    a0 = acc0;
    for (int k = 0; k < 20000 && (acc0 - a0) < 1000; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      req_a     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      req_b     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      req_cin   = 1'($urandom);
      @(posedge clk); #1;
    end
    check_eq("rand_done", 64'((acc0 - a0) >= 1000), 64'd1);
    drain();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
    end
    check_eq("end_credits", 64'(g_inst[0].u_dut.credits), 64'(DEPTH));
    check_eq("end_q0", 64'(g_inst[0].q.size()), 64'd0);
    check_eq("end_q1", 64'(g_inst[1].q.size()), 64'd0);
    check_eq("end_q2", 64'(g_inst[2].q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
